fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter STARTING_ADDR, default 32'h01000000, byte address of the first main-memory word.
REQ-002 SHALL have parameter MEM_DEPTH_BYTES, default 32'h00100000, size of the fetchable window in bytes.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_address  output  32  byte address presented to main memory (the current PC).
REQ-006 SHALL have port mem_read_write  output  1  memory command; constant READ (0).
REQ-007 SHALL have port mem_data_in  output  32  memory write data; constant 32'h0.
REQ-008 SHALL have port mem_data_out  input  32  little-endian instruction word, valid combinationally in the same cycle as mem_address.
REQ-009 SHALL have port redirect_valid  input  1  PC redirect request from a downstream stage.
REQ-010 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-011 SHALL have port inst_valid  output  1  inst/inst_pc hold a fetched instruction.
REQ-012 SHALL have port inst_ready  input  1  the decode stage accepts the instruction this cycle.
REQ-013 SHALL have port inst  output  32  fetched instruction word.
REQ-014 SHALL have port inst_pc  output  32  byte address of inst.
REQ-015 SHALL have port fetch_fault  output  1  fetch stopped on a misaligned or out-of-window PC.

Function
REQ-016 SHALL hold the PC in a 32-bit register and drive mem_address = PC combinationally.
REQ-017 SHALL buffer fetched words in a 2-entry FIFO of {pc, word}; inst_valid = FIFO not empty; inst/inst_pc = FIFO head.
REQ-018 Pop: the FIFO SHALL pop at a rising edge when inst_valid && inst_ready are both high.
REQ-019 Push: in RUN, when the FIFO is not full or a pop occurs in the same cycle, the block SHALL push {PC, mem_data_out} and set PC <= PC + 4.
REQ-020 When the FIFO is full and no pop occurs, the block SHALL NOT push, and the PC SHALL hold.
REQ-021 Simultaneous push and pop SHALL keep the occupancy unchanged and preserve order.
REQ-022 Latency: a word fetched at edge N SHALL appear on inst at cycle N+1 when the FIFO was empty.
REQ-023 FSM states: RUN and FAULT. RUN -> FAULT when PC[1:0] != 0 or PC is outside [STARTING_ADDR, STARTING_ADDR+MEM_DEPTH_BYTES-4]; no push occurs in that cycle.
REQ-024 In FAULT, fetch_fault SHALL be 1, no pushes SHALL occur, the PC SHALL hold, and already-buffered entries SHALL remain poppable.
REQ-025 Redirect: at an edge with redirect_valid=1, the block SHALL flush the FIFO, set PC <= redirect_pc and state <= RUN, with no push or pop that cycle.
REQ-026 Redirect SHALL take priority over push, pop and FAULT.
REQ-027 PC+4 SHALL wrap modulo 2^32; the wrapped value is caught by the window check of REQ-023.

Reset
REQ-028 While reset=1 at an edge, the block SHALL set PC <= STARTING_ADDR, FIFO <= empty and state <= RUN.
REQ-029 Reset values: inst_valid=0, fetch_fault=0, inst/inst_pc=0; reset SHALL override redirect and handshake.
REQ-030 Reset asserted mid-stream SHALL discard all buffered entries.

Structure
REQ-031 A shared package SHALL hold STARTING_ADDR, MEM_DEPTH_BYTES, READ=0, WRITE=1 and the fetch state encoding.
REQ-032 The FIFO SHALL be a sub-module fetch_fifo (2 entries × 64 bits, with push, pop, flush, full and empty) that the top instantiates once.

Verification
REQ-033 Streaming: reset, then inst_ready=1 and memory loaded with 0x00000013 at every word -> inst_pc sequence 0x01000000, 0x01000004, 0x01000008…, one per cycle from the first cycle after reset.
REQ-034 Backpressure: inst_ready=0 for 5 cycles -> exactly 2 entries buffered, PC held at 0x01000008, mem_address steady; on release, in-order delivery with no loss or duplicates.
REQ-035 Redirect: redirect_valid=1 with redirect_pc=0x01000040 while the FIFO is full -> next cycle inst_valid=0; the following cycle inst_pc=0x01000040.
REQ-036 Misaligned redirect 0x01000042 -> fetch_fault=1, inst_valid stays 0; a later redirect to 0x01000000 -> fetch_fault=0 and fetching resumes.
REQ-037 Window end: run to PC=0x010FFFFC -> that word is delivered, then PC=0x01100000 -> FAULT, no further pushes.
REQ-038 Reset mid-stream with 2 entries buffered -> next cycle inst_valid=0 and PC=0x01000000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   STARTING_ADDR / MEM_DEPTH_BYTES : default fetch window (byte addresses)
//   READ / WRITE                    : memory command encoding
//   fetch_state_t                   : fetch FSM encoding
//   fetch_entry_t                   : one buffered {pc, word} pair (64 bits)
//   pc_fetchable()                  : alignment + window check for a PC
package fetch_unit_pkg;

  localparam logic [31:0] STARTING_ADDR   = 32'h0100_0000;
  localparam logic [31:0] MEM_DEPTH_BYTES = 32'h0010_0000;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam int FIFO_WIDTH = 64;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  // A PC is fetchable when word aligned and inside
  // [base, base + depth - 4]. The upper bound is computed once so a PC that
  // wrapped past 2^32 lands below base and fails the lower-bound test.
  function automatic logic pc_fetchable(input logic [31:0] pc,
                                        input logic [31:0] base,
                                        input logic [31:0] depth);
    logic [31:0] last;
    last = base + depth - 32'd4;
    return (pc[1:0] == 2'b00) && (pc >= base) && (pc <= last);
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Two-entry FIFO holding fetched {pc, word} pairs.
//   clock      : clock
//   reset      : synchronous active-high reset, empties and clears storage
//   flush      : empties the FIFO (dominates push/pop)
//   push       : write push_data (ignored when full unless popping)
//   pop        : drop the head entry (ignored when empty)
//   push_data  : 64-bit entry to write
//   head_data  : current head entry (meaningless while empty)
//   full/empty : occupancy flags
module fetch_fifo
  import fetch_unit_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [FIFO_WIDTH-1:0] push_data,
  output logic [FIFO_WIDTH-1:0] head_data,
  output logic                  full,
  output logic                  empty
);

  logic       rd_ptr_reg, rd_ptr_next;
  logic       wr_ptr_reg, wr_ptr_next;
  logic [1:0] count_reg, count_next;
  logic       pop_en, push_en;

  assign empty = (count_reg == 2'd0);
  assign full  = (count_reg == 2'd2);

  // A push into a full FIFO is accepted when the head leaves in the same
  // cycle; occupancy stays the same and order is preserved by the pointers.
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);

  // One register per slot so each slot has a single driver.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    logic [FIFO_WIDTH-1:0] entry_reg;

    always_ff @(posedge clock) begin
      if (reset) begin
        entry_reg <= '0;
      end else if (!flush && push_en && (wr_ptr_reg == 1'(gi))) begin
        entry_reg <= push_data;
      end
    end
  end

  assign head_data = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      rd_ptr_next = 1'b0;
      wr_ptr_next = 1'b0;
      count_next  = 2'd0;
    end else begin
      if (pop_en)  rd_ptr_next = ~rd_ptr_reg;
      if (push_en) wr_ptr_next = ~wr_ptr_reg;
      if (push_en && !pop_en)      count_next = count_reg + 2'd1;
      else if (pop_en && !push_en) count_next = count_reg - 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks a PC through main memory, buffering
// {pc, word} pairs in a 2-entry FIFO toward the decode stage.
//   clock, reset        : clock and synchronous active-high reset
//   mem_address         : current PC presented to memory
//   mem_read_write      : always READ
//   mem_data_in         : always zero (no writes)
//   mem_data_out        : instruction word at mem_address, same cycle
//   redirect_valid/_pc  : flush and restart fetching at redirect_pc
//   inst_valid/_ready   : handshake with decode
//   inst / inst_pc      : FIFO head word and its byte address
//   fetch_fault         : fetching stopped on a bad PC
module fetch_unit #(
  parameter logic [31:0] STARTING_ADDR   = fetch_unit_pkg::STARTING_ADDR,
  parameter logic [31:0] MEM_DEPTH_BYTES = fetch_unit_pkg::MEM_DEPTH_BYTES
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] mem_address,
  output logic        mem_read_write,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

  import fetch_unit_pkg::*;

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic         pc_ok;
  logic         push, pop;
  logic         fifo_full, fifo_empty;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;
  logic [FIFO_WIDTH-1:0] head_data;

  assign pc_ok = pc_fetchable(pc_reg, STARTING_ADDR, MEM_DEPTH_BYTES);

  // A redirect suppresses both handshake directions: the FIFO is being
  // flushed, so nothing popped or pushed this cycle would be meaningful.
  assign pop  = !fifo_empty && inst_ready && !redirect_valid;
  assign push = (state_reg == ST_RUN) && pc_ok && (!fifo_full || pop)
                && !redirect_valid;

  assign push_entry = '{pc: pc_reg, word: mem_data_out};
  assign head_entry = fetch_entry_t'(head_data);

  fetch_fifo u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .pop       (pop),
    .push_data (push_entry),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_RUN;
      pc_reg    <= STARTING_ADDR;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    if (redirect_valid) begin
      state_next = ST_RUN;
      pc_next    = redirect_pc;
    end else begin
      if ((state_reg == ST_RUN) && !pc_ok) state_next = ST_FAULT;
      // PC + 4 wraps naturally at 32 bits; a wrapped PC fails pc_fetchable.
      if (push) pc_next = pc_reg + 32'd4;
    end
  end

  // Output logic
  always_comb begin
    mem_address    = pc_reg;
    mem_read_write = READ;
    mem_data_in    = 32'h0;
    fetch_fault    = (state_reg == ST_FAULT);
    inst_valid     = !fifo_empty;
    // Slots keep stale data after a pop; present zeros while nothing is held.
    inst           = fifo_empty ? 32'h0 : head_entry.word;
    inst_pc        = fifo_empty ? 32'h0 : head_entry.pc;
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] START = 32'h0100_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_entry_t;

  logic        clock;
  logic        reset;
  logic [31:0] mem_address;
  logic        mem_read_write;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  logic        mem_mode;
  exp_entry_t  exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;

  fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .mem_address    (mem_address),
    .mem_read_write (mem_read_write),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .fetch_fault    (fetch_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory image: mode 0 is all NOPs, mode 1 is an address-derived pattern.
  function automatic logic [31:0] word_at(input logic [31:0] addr, input logic mode);
    return mode ? {addr[15:0], ~addr[15:0]} : 32'h0000_0013;
  endfunction

  assign mem_data_out = word_at(mem_address, mem_mode);

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end else begin
      $display("[TB] ok %s = %h", name, actual);
    end
  endtask

  task automatic expect_entry(input logic [31:0] pc);
    exp_entry_t e;
    e.pc   = pc;
    e.word = word_at(pc, mem_mode);
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every accepted instruction is compared with the scoreboard head.
  always @(negedge clock) begin
    if (!reset && !redirect_valid && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_delivery: got pc %h with no entry expected", inst_pc);
      end else begin
        exp_entry_t e;
        e = exp_q.pop_front();
        tests_run++;
        if (inst_pc !== e.pc || inst !== e.word) begin
          tests_failed++;
          $display("FAIL delivery: got pc %h word %h expected pc %h word %h",
                   inst_pc, inst, e.pc, e.word);
        end else begin
          $display("[TB] delivered pc %h word %h", inst_pc, inst);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;          // reset must override a redirect
    redirect_pc    = 32'hDEAD_0000;
    mem_mode       = 1'b0;
    step();
    step();
    check("reset_inst_valid", 32'(inst_valid), 32'd0);
    check("reset_fetch_fault", 32'(fetch_fault), 32'd0);
    check("reset_inst", inst, 32'h0);
    check("reset_inst_pc", inst_pc, 32'h0);
    check("reset_mem_address", mem_address, START);
    check("mem_read_write", 32'(mem_read_write), 32'd0);
    check("mem_data_in", mem_data_in, 32'h0);

    // Streaming: one instruction per cycle from the first cycle after reset.
    reset          = 1'b0;
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    for (int k = 0; k < 7; k++) expect_entry(START + 32'(4 * k));
    for (int k = 0; k < 8; k++) begin
      step();
      check("stream_valid", 32'(inst_valid), 32'd1);
      check("stream_pc", inst_pc, START + 32'(4 * k));
    end
    inst_ready = 1'b0;
    step();
    step();
    check("fill_pc_held", mem_address, START + 32'd36);
    check("fill_head_pc", inst_pc, START + 32'd28);

    // Reset with two entries buffered discards them.
    reset = 1'b1;
    exp_q.delete();
    mem_mode = 1'b1;
    step();
    check("midreset_inst_valid", 32'(inst_valid), 32'd0);
    check("midreset_pc", mem_address, START);
    reset = 1'b0;

    // Backpressure: five stalled cycles, FIFO fills and PC holds at +8.
    for (int k = 0; k < 4; k++) expect_entry(START + 32'(4 * k));
    for (int i = 0; i < 5; i++) begin
      step();
      if (i >= 1) check("bp_pc_held", mem_address, START + 32'd8);
    end
    check("bp_valid", 32'(inst_valid), 32'd1);
    check("bp_head_pc", inst_pc, START);
    inst_ready = 1'b1;
    repeat (4) step();
    inst_ready = 1'b0;
    step();
    check("bp_refill_pc", mem_address, START + 32'd24);
    check("bp_refill_head", inst_pc, START + 32'd16);

    // Redirect while full.
    redirect_valid = 1'b1;
    redirect_pc    = START + 32'h40;
    step();
    redirect_valid = 1'b0;
    check("redir_flush_valid", 32'(inst_valid), 32'd0);
    inst_ready = 1'b1;
    expect_entry(START + 32'h40);
    expect_entry(START + 32'h44);
    step();
    check("redir_valid", 32'(inst_valid), 32'd1);
    check("redir_pc", inst_pc, START + 32'h40);
    step();
    step();
    inst_ready = 1'b0;

    // Misaligned redirect faults; redirect to a good PC recovers.
    redirect_valid = 1'b1;
    redirect_pc    = START + 32'h42;
    step();
    redirect_valid = 1'b0;
    check("misal_flush_valid", 32'(inst_valid), 32'd0);
    step();
    check("misal_fault", 32'(fetch_fault), 32'd1);
    check("misal_valid", 32'(inst_valid), 32'd0);
    step();
    check("misal_fault_hold", 32'(fetch_fault), 32'd1);
    check("misal_pc_hold", mem_address, START + 32'h42);
    check("misal_valid_hold", 32'(inst_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = START;
    step();
    redirect_valid = 1'b0;
    check("recover_fault", 32'(fetch_fault), 32'd0);
    step();
    check("recover_valid", 32'(inst_valid), 32'd1);
    check("recover_pc", inst_pc, START);
    check("recover_word", inst, word_at(START, 1'b1));

    // Window end: last word delivered, next PC faults.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h010F_FFF4;
    inst_ready     = 1'b1;
    expect_entry(32'h010F_FFF4);
    expect_entry(32'h010F_FFF8);
    expect_entry(32'h010F_FFFC);
    step();
    redirect_valid = 1'b0;
    check("win_flush_valid", 32'(inst_valid), 32'd0);
    step();
    check("win_first_pc", inst_pc, 32'h010F_FFF4);
    step();
    step();
    check("win_last_pc", inst_pc, 32'h010F_FFFC);
    check("win_end_addr", mem_address, 32'h0110_0000);
    step();
    check("win_fault", 32'(fetch_fault), 32'd1);
    check("win_valid", 32'(inst_valid), 32'd0);
    step();
    check("win_fault_hold", 32'(fetch_fault), 32'd1);
    check("win_no_push", 32'(inst_valid), 32'd0);
    check("win_pc_hold", mem_address, 32'h0110_0000);
    inst_ready = 1'b0;

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
